// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA scanout slice.
//   - 640x480@60 timing (visible / porch / sync / total for H and V)
//   - framebuffer geometry (160x120, 3-bit RGB words, 15-bit address)
//   - colour bit positions inside a framebuffer word (MSB = R)
//   - sync_flags_t: the sync/visible flags carried through the fetch pipeline
package vga_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_H_TOTAL   = 800;

  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_V_TOTAL   = 525;

  localparam int unsigned CNT_W         = 10;
  localparam int unsigned SCALE_SHIFT   = 2;
  localparam int unsigned FB_WIDTH      = 160;
  localparam int unsigned FB_HEIGHT     = 120;
  localparam int unsigned FB_ADDR_W     = 15;
  localparam int unsigned COLOUR_BITS   = 3;

  localparam int unsigned COL_R = 2;
  localparam int unsigned COL_G = 1;
  localparam int unsigned COL_B = 0;

  typedef struct packed {
    logic hs;       // active-low horizontal sync
    logic vs;       // active-low vertical sync
    logic visible;  // inside the 640x480 active area
  } sync_flags_t;

  localparam sync_flags_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, visible: 1'b0};

  // Start address of a framebuffer row: y*160 as a shift-add (160 = 128 + 32).
  function automatic logic [FB_ADDR_W-1:0] row_base(input logic [FB_ADDR_W-1:0] y);
    return (y << 7) + (y << 5);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable and raster counters for VGA timing.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   pix_en          toggles every clock; 1 on the first cycle after reset
//   h_count/v_count raster position, advance on pix_en
//   hs, vs          raw active-low syncs decoded from the counters
//   visible         h/v inside the active area
//   frame_tick      one-clock pulse on the pix_en where v enters vertical blanking
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hs,
  output logic             vs,
  output logic             visible,
  output logic             frame_tick
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en     <= 1'b1;
      h_count    <= '0;
      v_count    <= '0;
      frame_tick <= 1'b0;
    end else begin
      pix_en     <= ~pix_en;
      frame_tick <= 1'b0;
      if (pix_en) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          if (v_count == V_LAST) begin
            v_count <= '0;
          end else begin
            v_count <= v_count + CNT_W'(1);
          end
          // Pulse coincides with v stepping from the last visible line into blanking.
          if (v_count == V_VIS_LAST) begin
            frame_tick <= 1'b1;
          end
        end else begin
          h_count <= h_count + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    visible = (h_count < H_VIS_END) && (v_count < V_VIS_END);
    hs      = !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
    vs      = !((v_count >= VS_FIRST) && (v_count <= VS_LAST));
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer read side. Sweeps VGA timing, fetches each
// 160x120 framebuffer pixel (shown as a 4x4 block) and drives the DAC pins.
// Ports:
//   CLOCK_50, RESET        50 MHz clock, synchronous active-high reset
//   FB_ADDR, FB_RDEN, FB_Q framebuffer read port (synchronous RAM, 1-clock latency)
//   VGA_R/G/B              8-bit channel intensity (each FB bit replicated)
//   VGA_HS, VGA_VS         active-low syncs, aligned with the colour pins
//   VGA_BLANK_N            high only for visible pixels
//   VGA_SYNC_N             tied low
//   VGA_CLK                25 MHz pixel clock, rising edge mid-way through each pixel
//   FRAME_TICK             one-clock pulse at start of vertical blanking
//   H_COUNT, V_COUNT       raster counters for debug
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT     = VGA_V_FRONT,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter int unsigned SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
  parameter int unsigned COLOUR_BITS = vga_pkg::COLOUR_BITS
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  output logic [FB_ADDR_W-1:0]   FB_ADDR,
  output logic                   FB_RDEN,
  input  logic [COLOUR_BITS-1:0] FB_Q,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic                   VGA_CLK,
  output logic                   FRAME_TICK,
  output logic [CNT_W-1:0]       H_COUNT,
  output logic [CNT_W-1:0]       V_COUNT
);

  logic             pix_en;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             hs;
  logic             vs;
  logic             visible;
  logic             frame_tick;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk        (CLOCK_50),
    .reset      (RESET),
    .pix_en     (pix_en),
    .h_count    (h_count),
    .v_count    (v_count),
    .hs         (hs),
    .vs         (vs),
    .visible    (visible),
    .frame_tick (frame_tick)
  );

  logic [FB_ADDR_W-1:0] fb_col;
  logic [FB_ADDR_W-1:0] fb_row;
  logic [FB_ADDR_W-1:0] fb_addr_next;

  always_comb begin
    fb_col       = FB_ADDR_W'(h_count >> SCALE_SHIFT);
    fb_row       = FB_ADDR_W'(v_count >> SCALE_SHIFT);
    fb_addr_next = row_base(fb_row) + fb_col;
  end

  // Flags ride alongside the RAM access so the sync/blank pins land on the
  // same edge as the colour data they belong to.
  sync_flags_t flags_a;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      FB_ADDR     <= '0;
      FB_RDEN     <= 1'b0;
      flags_a     <= SYNC_IDLE;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      VGA_CLK <= ~pix_en;
      if (pix_en) begin
        // Stage A: issue the read for the current raster position.
        FB_ADDR <= visible ? fb_addr_next : '0;
        FB_RDEN <= visible;
        flags_a <= '{hs: hs, vs: vs, visible: visible};
        // Stage B: FB_Q now answers the address issued one pixel earlier.
        VGA_R       <= {8{FB_Q[COL_R] & flags_a.visible}};
        VGA_G       <= {8{FB_Q[COL_G] & flags_a.visible}};
        VGA_B       <= {8{FB_Q[COL_B] & flags_a.visible}};
        VGA_HS      <= flags_a.hs;
        VGA_VS      <= flags_a.vs;
        VGA_BLANK_N <= flags_a.visible;
      end
    end
  end

  assign VGA_SYNC_N = 1'b0;
  assign FRAME_TICK = frame_tick;
  assign H_COUNT    = h_count;
  assign V_COUNT    = v_count;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench for vga_scanout. Horizontal timing is the
// standard 800-clock line; the frame is shortened to 8 visible lines
// (2 front, 2 sync, 2 back, 14 total) so whole frames fit in a short run.
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] fb_addr;
  logic        fb_rden;
  logic [2:0]  fb_q = 3'b000;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_tick;
  logic [9:0]  h_count, v_count;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic force_ones = 1'b0;

  int b1, b2, hf, hr, t1, t2, vf, vr, b0, dummy;

  localparam int LIMIT = 30000;

  always #10 clk = ~clk;

  // Framebuffer model: synchronous read returning the low address bits.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    fb_q <= force_ones ? 3'b111 : fb_addr[2:0];
  end

  vga_scanout #(
    .V_VISIBLE (8),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (2)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .FB_ADDR     (fb_addr),
    .FB_RDEN     (fb_rden),
    .FB_Q        (fb_q),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_blank_n),
    .VGA_SYNC_N  (vga_sync_n),
    .VGA_CLK     (vga_clk),
    .FRAME_TICK  (frame_tick),
    .H_COUNT     (h_count),
    .V_COUNT     (v_count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return vga_blank_n;
      1:       return vga_hs;
      2:       return vga_vs;
      default: return frame_tick;
    endcase
  endfunction

  // Advance until the selected pin reaches lvl; returns the cycle stamp.
  task automatic wait_level(input int sel, input logic lvl, input string tag, output int at);
    int n = 0;
    while (sig(sel) !== lvl && n < LIMIT) begin
      tick();
      n++;
    end
    at = cyc;
    vectors++;
    assert (n < LIMIT) else begin
      miscompares++;
      $error("FAIL %s: timeout after %0d cycles, level %0b not seen", tag, n, lvl);
    end
  endtask

  // Advance to the pix_en cycle (VGA_CLK high) holding raster position (h,v).
  task automatic wait_hv(input int h, input int v);
    int n = 0;
    while (!(h_count == 10'(h) && v_count == 10'(v) && vga_clk === 1'b1) && n < LIMIT) begin
      tick();
      n++;
    end
    vectors++;
    assert (n < LIMIT) else begin
      miscompares++;
      $error("FAIL wait_hv: timeout, observed h=%0d v=%0d expected h=%0d v=%0d",
             h_count, v_count, h, v);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_hs",    vga_hs, 1);
    check("rst_vs",    vga_vs, 1);
    check("rst_blank", vga_blank_n, 0);
    check("rst_rgb",   {vga_r, vga_g, vga_b}, 0);
    check("rst_rden",  fb_rden, 0);
    check("rst_addr",  fb_addr, 0);
    check("rst_tick",  frame_tick, 0);
    check("rst_h",     h_count, 0);
    check("rst_v",     v_count, 0);
    check("rst_vclk",  vga_clk, 0);
    check("sync_n",    vga_sync_n, 0);

    // First pixel after release.
    rst = 1'b0;
    tick();
    check("p0_h",    h_count, 1);
    check("p0_rden", fb_rden, 1);
    check("p0_addr", fb_addr, 0);
    check("p0_vclk", vga_clk, 0);
    tick();
    check("p0_vclk_hi", vga_clk, 1);
    tick();
    check("p0_blank", vga_blank_n, 1);
    check("p0_rgb",   {vga_r, vga_g, vga_b}, 0);

    // (20,0) -> address 5 -> R and B.
    wait_hv(20, 0);
    tick();
    check("a20_addr", fb_addr, 5);
    tick(); tick();
    check("a20_rgb", {vga_r, vga_g, vga_b}, 24'hFF00FF);

    // Line timing measured on the pins.
    wait_level(0, 1'b0, "blank_end0", dummy);
    wait_level(0, 1'b1, "blank_rise1", b1);
    wait_level(1, 1'b0, "hs_fall", hf);
    wait_level(1, 1'b1, "hs_rise", hr);
    wait_level(0, 1'b0, "blank_end1", dummy);
    wait_level(0, 1'b1, "blank_rise2", b2);
    check("hs_offset", hf - b1, 1312);
    check("hs_width",  hr - hf, 192);
    check("line_per",  b2 - b1, 1600);

    // (8,4) -> 162 -> data 010 -> G only.
    wait_hv(8, 4);
    tick();
    check("a162_addr", fb_addr, 162);
    check("a162_rden", fb_rden, 1);
    tick(); tick();
    check("a162_rgb", {vga_r, vga_g, vga_b}, 24'h00FF00);

    // (13,5) -> 163 -> data 011 -> G and B.
    wait_hv(13, 5);
    tick();
    check("a163_addr", fb_addr, 163);
    tick(); tick();
    check("a163_rgb", {vga_r, vga_g, vga_b}, 24'h00FFFF);

    // Last visible pixel, then the blanked pixel with RAM data forced high.
    wait_hv(639, 7);
    force_ones = 1'b1;
    tick();
    check("last_addr", fb_addr, 319);
    tick(); tick();
    check("last_rgb",   {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    check("last_blank", vga_blank_n, 1);
    check("h640_rden",  fb_rden, 0);
    check("h640_addr",  fb_addr, 0);
    tick(); tick();
    check("h640_blank", vga_blank_n, 0);
    check("h640_rgb",   {vga_r, vga_g, vga_b}, 0);
    force_ones = 1'b0;

    // Frame tick, vertical sync, frame period.
    wait_level(3, 1'b1, "tick1", t1);
    check("tick_v", v_count, 8);
    check("tick_h", h_count, 0);
    tick();
    check("tick_width", frame_tick, 0);
    wait_level(2, 1'b0, "vs_fall", vf);
    wait_level(2, 1'b1, "vs_rise", vr);
    wait_level(0, 1'b1, "frame_blank_rise", b0);
    wait_level(3, 1'b1, "tick2", t2);
    check("vs_offset",    vf - t1, 3204);
    check("vs_width",     vr - vf, 3200);
    check("frame_start",  b0 - t1, 9604);
    check("frame_period", t2 - t1, 22400);

    // One-clock reset mid-line.
    wait_hv(300, 2);
    check("pre_addr",  fb_addr, 74);
    check("pre_blank", vga_blank_n, 1);
    rst = 1'b1;
    tick();
    check("mid_blank", vga_blank_n, 0);
    check("mid_rgb",   {vga_r, vga_g, vga_b}, 0);
    check("mid_hs",    vga_hs, 1);
    check("mid_vs",    vga_vs, 1);
    check("mid_rden",  fb_rden, 0);
    check("mid_addr",  fb_addr, 0);
    check("mid_h",     h_count, 0);
    check("mid_v",     v_count, 0);
    check("mid_vclk",  vga_clk, 0);
    check("mid_tick",  frame_tick, 0);
    rst = 1'b0;
    tick();
    check("rel_rden", fb_rden, 1);
    check("rel_addr", fb_addr, 0);
    check("rel_h",    h_count, 1);
    tick(); tick();
    check("rel_blank", vga_blank_n, 1);
    check("rel_rgb",   {vga_r, vga_g, vga_b}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
